// File: rtl/sync_gen_pkg.sv
// sync_gen_pkg -- shared constants for the sync pulse generator.
//   sg_state_e : FSM state encoding (IDLE=0, ARMED=1, PULSE=2)
//   cnt_width  : width needed to hold a count of 0..n
package sync_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2
  } sg_state_e;

  // ceil(log2(n+1)), never less than 1 bit
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_extend.sv
// pulse_extend -- fixed-length pulse timer.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : begin a pulse; the first active cycle follows this edge
//   active : timer is running (PULSE_WIDTH cycles per start)
//   done   : last active cycle; the owner leaves its pulse state at the next edge
module pulse_extend
  import sync_gen_pkg::*;
#(
  parameter int PULSE_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic active,
  output logic done
);

  localparam int CW = cnt_width(PULSE_WIDTH);

  // cnt holds the 1-based index of the current pulse cycle, 0 when idle
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (start)   cnt <= CW'(1);
    else if (done)    cnt <= '0;
    else if (active)  cnt <= cnt + CW'(1);
  end

  assign active = (cnt != '0);
  assign done   = active && (cnt == CW'(PULSE_WIDTH));

endmodule

// File: rtl/sync_gen.sv
// sync_gen -- arms on request, then emits a PULSE_WIDTH-cycle sync pulse when
// the qualified upstream count equals MATCH_VALUE.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, overrides everything
//   en     : count is valid this cycle
//   count  : upstream counter value
//   arm    : request to arm (only honoured in IDLE)
//   disarm : request to disarm (wins over arm and over a match)
//   sync   : registered sync pulse
//   armed  : waiting for a match
//   busy   : pulse in progress
//   events : pulses issued, wraps
module sync_gen
  import sync_gen_pkg::*;
#(
  parameter              ARCHITECTURE = "BEHAVIORAL",
  parameter int          DATA_WIDTH   = 8,
  parameter int unsigned MATCH_VALUE  = 255,
  parameter int          PULSE_WIDTH  = 4,
  parameter int          CONTINUOUS   = 0,
  parameter int          EVENT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DATA_WIDTH-1:0]  count,
  input  logic                   arm,
  input  logic                   disarm,
  output logic                   sync,
  output logic                   armed,
  output logic                   busy,
  output logic [EVENT_WIDTH-1:0] events
);

  localparam bit BEHAV = (ARCHITECTURE == "BEHAVIORAL");

  if (BEHAV) begin : g_behav
    sg_state_e state;
    logic      dis_lat;   // disarm seen while pulsing; applied when the pulse ends
    logic      hit;
    logic      pe_start;
    logic      pe_active;
    logic      pe_done;

    assign hit      = en && (count == DATA_WIDTH'(MATCH_VALUE));
    // disarm beats a simultaneous match
    assign pe_start = (state == ST_ARMED) && !disarm && hit;

    pulse_extend #(.PULSE_WIDTH(PULSE_WIDTH)) u_pe (
      .clk    (clk),
      .rst    (rst),
      .start  (pe_start),
      .active (pe_active),
      .done   (pe_done)
    );

    // Outputs are written alongside the state so they are plain flops that
    // always equal the decode of the state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= ST_IDLE;
        dis_lat <= 1'b0;
        sync    <= 1'b0;
        busy    <= 1'b0;
        armed   <= 1'b0;
        events  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm && !disarm) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (disarm) begin
              state <= ST_IDLE;
              armed <= 1'b0;
            end else if (hit) begin
              state  <= ST_PULSE;
              armed  <= 1'b0;
              sync   <= 1'b1;
              busy   <= 1'b1;
              events <= events + EVENT_WIDTH'(1);
            end
          end
          ST_PULSE: begin
            if (disarm) dis_lat <= 1'b1;
            // !pe_active recovers if the timer and the FSM ever disagree
            if (pe_done || !pe_active) begin
              sync    <= 1'b0;
              busy    <= 1'b0;
              dis_lat <= 1'b0;
              // a disarm on the final pulse cycle counts as latched too
              if ((CONTINUOUS != 0) && !dis_lat && !disarm) begin
                state <= ST_ARMED;
                armed <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            dis_lat <= 1'b0;
            sync    <= 1'b0;
            busy    <= 1'b0;
            armed   <= 1'b0;
          end
        endcase
      end
    end
  end else begin : g_unsupported
    // only the behavioural implementation exists; other selections stay inert
    assign sync   = 1'b0;
    assign armed  = 1'b0;
    assign busy   = 1'b0;
    assign events = '0;
  end

endmodule
